instr_fetch: RTL and testbench

- Fetch stage that sits directly upstream of the instruction stall stage.
- Owns the PC and issues single-outstanding word reads to the memory controller.
- Discards stale data after a branch/jump redirect.
- Presents instr_out/pc_out with instr_valid downstream and honours the hazard-unit stall.

---
 rtl/instr_fetch.sv | 133 +++++++++++++
 tb/tb_instr_fetch.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues single-outstanding imem reads, squashes on redirect, honours stall.
// Optional feature macro: PC_ALIGN_CHECK_EN (adds misalign_err, word-aligns redirect targets).
module instr_fetch #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rdy,
    input  logic              imem_valid,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              instr_valid
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic              misalign_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DROP
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_instr_out;
    logic [ADDR_W-1:0] r_pc_out;
    logic              r_instr_valid;
    logic [ADDR_W-1:0] w_redirect_target;
    logic              w_slot_free;
    logic              w_consume;
    logic              w_req;
    logic              w_capture;

    assign w_slot_free = !r_instr_valid || !stall;
    assign w_consume   = r_instr_valid && !stall;

`ifdef PC_ALIGN_CHECK_EN
    logic r_misalign_err;

    assign w_redirect_target = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign misalign_err      = r_misalign_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign_err <= 1'b0;
        end else begin
            r_misalign_err <= redirect && (redirect_pc[1:0] != 2'b00);
        end
    end
`else
    assign w_redirect_target = redirect_pc;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_next = S_REQ;
            end
            S_REQ: begin
                w_req = w_slot_free && !redirect;
                if (w_req && imem_rdy) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    w_state_next = imem_valid ? S_REQ : S_DROP;
                end else if (imem_valid) begin
                    w_capture    = 1'b1;
                    w_state_next = S_REQ;
                end
            end
            S_DROP: begin
                // The stale word closes the outstanding read even if another redirect
                // lands in the same cycle; waiting on would never see a further word.
                if (imem_valid) begin
                    w_state_next = S_REQ;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_VEC;
            r_instr_out   <= 32'h0000_0000;
            r_pc_out      <= '0;
            r_instr_valid <= 1'b0;
        end else if (redirect) begin
            r_pc          <= w_redirect_target;
            r_instr_valid <= 1'b0;
        end else if (w_capture) begin
            r_instr_out   <= imem_rdata;
            r_pc_out      <= r_pc;
            r_instr_valid <= 1'b1;
            r_pc          <= r_pc + ADDR_W'(4);
        end else if (w_consume) begin
            r_instr_valid <= 1'b0;
        end
    end

    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign instr_out   = r_instr_out;
    assign pc_out      = r_pc_out;
    assign instr_valid = r_instr_valid;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, hand sequences (wrap, misalign, mid-flight reset),
// then randomized traffic against a program-order delivery model with a behavioural memory controller.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rdy;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;
`ifdef PC_ALIGN_CHECK_EN
    logic        misalign_err;
`endif

    int checks = 0;
    int errors = 0;

    instr_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdy    (imem_rdy),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .instr_out   (instr_out),
        .pc_out      (pc_out),
        .instr_valid (instr_valid)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .misalign_err(misalign_err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        st;
        logic        rd;
        logic [31:0] rpc;
        logic        rdy;
        logic        vld;
        logic [31:0] rdat;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl [28];

    function automatic vec_t mk(input logic st, rd, input logic [31:0] rpc, input logic rdy, vld,
                                input logic [31:0] rdat, input logic e_req, input logic [31:0] e_addr,
                                input logic e_iv, input logic [31:0] e_instr, e_pc);
        vec_t v;
        v.st = st; v.rd = rd; v.rpc = rpc; v.rdy = rdy; v.vld = vld; v.rdat = rdat;
        v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv; v.e_instr = e_instr; v.e_pc = e_pc;
        return v;
    endfunction

    // Memory contents seen by the random phase: any fixed scramble of the address.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_A5A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change just after posedge; outputs are sampled on the following negedge.
    task automatic drive(input logic st, rd, input logic [31:0] rpc, input logic rdy, vld,
                         input logic [31:0] rdat);
        stall = st; redirect = rd; redirect_pc = rpc;
        imem_rdy = rdy; imem_valid = vld; imem_rdata = rdat;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_rdy = 1'b0; imem_valid = 1'b0; imem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    logic        outst;
    logic [31:0] pend_addr;
    int          lat;
    logic [31:0] exp_pc;
    int          delivered;
    logic        accepted;
    logic [31:0] acc_addr;

    initial begin
        //                st rd rpc           rdy vld rdat          req addr         iv instr         pc
        tbl[0]  = mk(0, 0, 0,            1, 0, 0,            0, 32'h0,       0, 0,            0);
        tbl[1]  = mk(0, 0, 0,            1, 0, 0,            1, 32'h0,       0, 0,            0);
        tbl[2]  = mk(0, 0, 0,            1, 0, 0,            0, 32'h0,       0, 0,            0);
        tbl[3]  = mk(0, 0, 0,            1, 1, 32'hA000_0000, 0, 32'h0,      0, 0,            0);
        tbl[4]  = mk(0, 0, 0,            1, 0, 0,            1, 32'h4,       1, 32'hA000_0000, 32'h0);
        tbl[5]  = mk(0, 0, 0,            1, 0, 0,            0, 32'h4,       0, 0,            0);
        tbl[6]  = mk(0, 0, 0,            1, 1, 32'hA000_0001, 0, 32'h4,      0, 0,            0);
        tbl[7]  = mk(0, 0, 0,            1, 0, 0,            1, 32'h8,       1, 32'hA000_0001, 32'h4);
        tbl[8]  = mk(0, 0, 0,            1, 1, 32'hA000_0002, 0, 32'h8,      0, 0,            0);
        tbl[9]  = mk(1, 0, 0,            1, 0, 0,            0, 32'hC,       1, 32'hA000_0002, 32'h8);
        tbl[10] = mk(1, 0, 0,            1, 0, 0,            0, 32'hC,       1, 32'hA000_0002, 32'h8);
        tbl[11] = mk(1, 0, 0,            1, 0, 0,            0, 32'hC,       1, 32'hA000_0002, 32'h8);
        tbl[12] = mk(1, 0, 0,            1, 0, 0,            0, 32'hC,       1, 32'hA000_0002, 32'h8);
        tbl[13] = mk(0, 0, 0,            1, 0, 0,            1, 32'hC,       1, 32'hA000_0002, 32'h8);
        tbl[14] = mk(0, 1, 32'h100,      1, 0, 0,            0, 32'hC,       0, 0,            0);
        tbl[15] = mk(0, 0, 0,            1, 0, 0,            0, 32'h100,     0, 0,            0);
        tbl[16] = mk(0, 0, 0,            1, 0, 0,            0, 32'h100,     0, 0,            0);
        tbl[17] = mk(0, 0, 0,            1, 1, 32'hA000_0003, 0, 32'h100,    0, 0,            0);
        tbl[18] = mk(0, 0, 0,            1, 0, 0,            1, 32'h100,     0, 0,            0);
        tbl[19] = mk(0, 1, 32'h200,      1, 1, 32'hA000_0004, 0, 32'h100,    0, 0,            0);
        tbl[20] = mk(0, 0, 0,            1, 0, 0,            1, 32'h200,     0, 0,            0);
        tbl[21] = mk(0, 0, 0,            1, 1, 32'hA000_0005, 0, 32'h200,    0, 0,            0);
        tbl[22] = mk(1, 1, 32'h300,      1, 0, 0,            0, 32'h204,     1, 32'hA000_0005, 32'h200);
        tbl[23] = mk(1, 0, 0,            1, 0, 0,            1, 32'h300,     0, 0,            0);
        tbl[24] = mk(0, 0, 0,            1, 1, 32'hA000_0006, 0, 32'h300,    0, 0,            0);
        tbl[25] = mk(0, 0, 0,            0, 0, 0,            1, 32'h304,     1, 32'hA000_0006, 32'h300);
        tbl[26] = mk(0, 0, 0,            1, 0, 0,            1, 32'h304,     0, 0,            0);
        tbl[27] = mk(0, 0, 0,            1, 0, 0,            0, 32'h304,     0, 0,            0);

        do_reset();
        @(negedge clk);
        chk("reset imem_req", imem_req, 1'b0);
        chk("reset imem_addr", imem_addr, 32'h0);
        chk("reset instr_valid", instr_valid, 1'b0);
        chk("reset instr_out", instr_out, 32'h0);
        chk("reset pc_out", pc_out, 32'h0);
`ifdef PC_ALIGN_CHECK_EN
        chk("reset misalign_err", misalign_err, 1'b0);
`endif
        $display("reset: req=%0d addr=%h iv=%0d", imem_req, imem_addr, instr_valid);
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 28; i++) begin
            drive(tbl[i].st, tbl[i].rd, tbl[i].rpc, tbl[i].rdy, tbl[i].vld, tbl[i].rdat);
            chk($sformatf("row%0d imem_req", i), imem_req, tbl[i].e_req);
            chk($sformatf("row%0d imem_addr", i), imem_addr, tbl[i].e_addr);
            chk($sformatf("row%0d instr_valid", i), instr_valid, tbl[i].e_iv);
            if (tbl[i].e_iv) begin
                chk($sformatf("row%0d instr_out", i), instr_out, tbl[i].e_instr);
                chk($sformatf("row%0d pc_out", i), pc_out, tbl[i].e_pc);
            end
            $display("row %0d: req=%0d addr=%h iv=%0d instr=%h pc=%h",
                     i, imem_req, imem_addr, instr_valid, instr_out, pc_out);
            tick();
        end

        // PC wrap: redirect to the last word, drain the stale read, fetch, check the wrapped PC.
        drive(0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        chk("wrap redirect req", imem_req, 1'b0);
        tick();
        drive(0, 0, 0, 0, 1, 32'hBAD0_0000);
        chk("wrap drop addr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap drop req", imem_req, 1'b0);
        tick();
        drive(0, 0, 0, 1, 0, 0);
        chk("wrap req", imem_req, 1'b1);
        chk("wrap req addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        drive(0, 0, 0, 0, 1, 32'hA000_0007);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("wrap instr_valid", instr_valid, 1'b1);
        chk("wrap pc_out", pc_out, 32'hFFFF_FFFC);
        chk("wrap instr_out", instr_out, 32'hA000_0007);
        chk("wrap next addr", imem_addr, 32'h0000_0000);
        $display("wrap: pc_out=%h instr=%h next_addr=%h", pc_out, instr_out, imem_addr);
        tick();

        // Misaligned redirect target.
        drive(0, 1, 32'h102, 1, 0, 0);
        chk("misalign redirect req", imem_req, 1'b0);
`ifdef PC_ALIGN_CHECK_EN
        chk("misalign before", misalign_err, 1'b0);
`endif
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("misalign req", imem_req, 1'b1);
`ifdef PC_ALIGN_CHECK_EN
        chk("misalign pulse", misalign_err, 1'b1);
        chk("misalign addr", imem_addr, 32'h100);
`else
        chk("unaligned addr", imem_addr, 32'h102);
`endif
        $display("misalign: addr=%h", imem_addr);
        tick();
        drive(0, 0, 0, 0, 0, 0);
`ifdef PC_ALIGN_CHECK_EN
        chk("misalign one cycle", misalign_err, 1'b0);
`endif
        chk("misalign hold req", imem_req, 1'b1);
        tick();

        // Reset with a read in flight; a late word must not be taken.
        drive(0, 0, 0, 1, 0, 0);
        chk("midrst accept", imem_req, 1'b1);
        tick();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        chk("midrst iv", instr_valid, 1'b0);
        chk("midrst req", imem_req, 1'b0);
        chk("midrst addr", imem_addr, 32'h0);
        tick();
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 1, 32'hDEAD_0000);
        chk("midrst idle req", imem_req, 1'b0);
        tick();
        drive(0, 0, 0, 0, 1, 32'hDEAD_0001);
        chk("midrst req after idle", imem_req, 1'b1);
        chk("midrst stale iv", instr_valid, 1'b0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("midrst stale ignored", instr_valid, 1'b0);
        chk("midrst still req", imem_req, 1'b1);
        chk("midrst addr hold", imem_addr, 32'h0);
        $display("midreset: iv=%0d req=%0d addr=%h", instr_valid, imem_req, imem_addr);
        tick();

        // Random traffic: delivered instructions must follow program order from the last redirect.
        do_reset();
        rst_n = 1'b1;
        outst = 1'b0; pend_addr = '0; lat = 0;
        exp_pc = 32'h0; delivered = 0;
        for (int c = 0; c < 3000; c++) begin
            stall       = ($urandom_range(0, 99) < 30);
            redirect    = ($urandom_range(0, 99) < 4);
            redirect_pc = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_3FFC);
            imem_rdy    = ($urandom_range(0, 99) < 60);
            imem_valid  = outst && (lat == 0);
            imem_rdata  = imem_valid ? word_of(pend_addr) : $urandom;
            @(negedge clk);
            if (instr_valid) begin
                chk($sformatf("rand%0d pc_out", c), pc_out, exp_pc);
                chk($sformatf("rand%0d instr_out", c), instr_out, word_of(exp_pc));
            end
            if (imem_req) begin
                chk($sformatf("rand%0d single outstanding", c), outst, 1'b0);
                chk($sformatf("rand%0d req while blocked", c),
                    (instr_valid && stall) || redirect, 1'b0);
            end
            if (imem_valid) begin
                chk($sformatf("rand%0d data into full stalled slot", c), instr_valid && stall, 1'b0);
            end
            accepted = imem_req && imem_rdy;
            acc_addr = imem_addr;
            if (redirect) begin
                exp_pc = redirect_pc;
            end else if (instr_valid && !stall) begin
                $display("rand %0d: deliver pc=%h instr=%h", c, pc_out, instr_out);
                delivered++;
                exp_pc = exp_pc + 32'd4;
            end
            tick();
            if (imem_valid) begin
                outst = 1'b0;
            end else if (outst && lat > 0) begin
                lat--;
            end
            if (accepted) begin
                outst     = 1'b1;
                pend_addr = acc_addr;
                lat       = $urandom_range(0, 3);
            end
        end
        chk("rand progress", 32'(delivered > 100), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
